sipo_frame_ctrl: RTL and testbench

Receive-frame controller that sequences an 8-bit serial-in/parallel-out shift register. It detects start bits on a strobed serial line, gates exactly DATA_W shifts into the SIPO, and optionally checks parity and the stop bit. Completed bytes go into a one-entry holding register with a valid/ready handshake. It sits between the serial pin-side bit strobe logic and the byte-wide consumer.

---
 rtl/sipo_pkg.sv | 15 +
 rtl/sipo_frame_ctrl_if.sv | 13 +
 rtl/sipo_shift8.sv | 37 +++
 rtl/sipo_frame_ctrl.sv | 130 +++++++++++++
 tb/tb_sipo_frame_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial receive-frame controller.
package sipo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } sipo_state_e;

  localparam int DATA_W_DEF       = 8;
  localparam bit PARITY_MODE_EVEN = 1'b0;
  localparam bit PARITY_MODE_ODD  = 1'b1;

endpackage

// File: rtl/sipo_frame_ctrl_if.sv
// Byte-side valid/ready handshake between the frame controller and its consumer.
interface sipo_frame_ctrl_if
  import sipo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/sipo_shift8.sv
// Serial-in/parallel-out shift register; new bits enter at bit 0, clear wins over shift.
module sipo_shift8
  import sipo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shift_en,
  input  logic              clr,
  input  logic              din,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] q_q;
  logic [DATA_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (shift_en) begin
      q_d = {q_q[DATA_W-2:0], din};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Receive-frame sequencer: start detect, DATA_W shifts, optional parity, stop check,
// and a one-entry holding register toward the byte consumer.
module sipo_frame_ctrl
  import sipo_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = PARITY_MODE_EVEN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ser_in,
  input  logic                     bit_stb,
  sipo_frame_ctrl_if.master        out_if,
  output logic                     busy,
  output logic                     parity_err,
  output logic                     frame_err,
  output logic                     overrun
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  sipo_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              par_ok_q, par_ok_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;

  logic              shift_en;
  logic              sipo_clr;
  logic [DATA_W-1:0] sipo_q;

  sipo_shift8 #(.DATA_W(DATA_W)) u_shift (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .clr      (sipo_clr),
    .din      (ser_in),
    .q        (sipo_q)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    par_ok_d = par_ok_q;
    data_d   = data_q;
    valid_d  = valid_q;
    perr_d   = 1'b0;
    ferr_d   = 1'b0;
    ovr_d    = 1'b0;
    shift_en = 1'b0;
    sipo_clr = 1'b0;

    if (valid_q && out_if.out_ready) begin
      valid_d = 1'b0;
    end

    if (bit_stb) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!ser_in) begin
            sipo_clr = 1'b1;
            cnt_d    = '0;
            par_ok_d = 1'b1;
            state_d  = ST_DATA;
          end
        end
        ST_DATA: begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = PARITY_EN ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          par_ok_d = (((^sipo_q) ^ ser_in) == PARITY_ODD);
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          // Priority: framing beats parity beats overrun.
          if (!ser_in) begin
            ferr_d = 1'b1;
          end else if (PARITY_EN && !par_ok_q) begin
            perr_d = 1'b1;
          end else if (!valid_q || out_if.out_ready) begin
            data_d  = sipo_q;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      par_ok_q <= 1'b1;
      data_q   <= '0;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      par_ok_q <= par_ok_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  assign out_if.out_data  = data_q;
  assign out_if.out_valid = valid_q;
  assign busy             = (state_q != ST_IDLE);
  assign parity_err       = perr_q;
  assign frame_err        = ferr_q;
  assign overrun          = ovr_q;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench: instance A uses even parity, instance B has parity disabled.
module tb_sipo_frame_ctrl;
  import sipo_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ser_a = 1'b1, stb_a = 1'b0;
  logic ser_b = 1'b1, stb_b = 1'b0;
  logic busy_a, perr_a, ferr_a, ovr_a;
  logic busy_b, perr_b, ferr_b, ovr_b;

  int n_tot = 0;
  int n_bad = 0;

  int np_a = 0, nf_a = 0, no_a = 0, nv_a = 0;
  int np_b = 0, nf_b = 0, no_b = 0;
  logic [7:0] got_a[$];
  logic [7:0] got_b[$];

  sipo_frame_ctrl_if #(.DATA_W(8)) if_a ();
  sipo_frame_ctrl_if #(.DATA_W(8)) if_b ();

  sipo_frame_ctrl #(.DATA_W(8), .PARITY_EN(1'b1), .PARITY_ODD(PARITY_MODE_EVEN)) dut_a (
    .clk(clk), .reset(reset), .ser_in(ser_a), .bit_stb(stb_a), .out_if(if_a.master),
    .busy(busy_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a)
  );

  sipo_frame_ctrl #(.DATA_W(8), .PARITY_EN(1'b0), .PARITY_ODD(PARITY_MODE_EVEN)) dut_b (
    .clk(clk), .reset(reset), .ser_in(ser_b), .bit_stb(stb_b), .out_if(if_b.master),
    .busy(busy_b), .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (perr_a) np_a++;
      if (ferr_a) nf_a++;
      if (ovr_a) no_a++;
      if (if_a.out_valid) nv_a++;
      if (if_a.out_valid && if_a.out_ready) got_a.push_back(if_a.out_data);
      if (perr_b) np_b++;
      if (ferr_b) nf_b++;
      if (ovr_b) no_b++;
      if (if_b.out_valid && if_b.out_ready) got_b.push_back(if_b.out_data);
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] frame_a(input logic [7:0] d, input logic par, input logic stop);
    return {1'b0, d, par, stop};
  endfunction

  function automatic logic [9:0] frame_b(input logic [7:0] d);
    return {1'b0, d, 1'b1};
  endfunction

  task automatic idle(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  // Sends bits MSB-first; gap=1 keeps the strobe high on consecutive cycles.
  task automatic strobe_bits(input bit on_b, input logic [31:0] bits, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      if (on_b) begin ser_b = bits[n-1-i]; stb_b = 1'b1; end
      else      begin ser_a = bits[n-1-i]; stb_a = 1'b1; end
      @(posedge clk); #1;
      stb_a = 1'b0;
      stb_b = 1'b0;
      for (int j = 1; j < gap; j++) begin @(posedge clk); #1; end
    end
  endtask

  task automatic clr_mon();
    np_a = 0; nf_a = 0; no_a = 0; nv_a = 0;
    np_b = 0; nf_b = 0; no_b = 0;
    got_a.delete();
    got_b.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    if_a.out_ready = 1'b0;
    if_b.out_ready = 1'b0;
    idle(3);
    chk_eq("rst_data", if_a.out_data, 32'h00);
    chk_eq("rst_valid", if_a.out_valid, 0);
    chk_eq("rst_busy", busy_a, 0);
    chk_eq("rst_errs", {perr_a, ferr_a, ovr_a}, 0);
    reset = 1'b0;
    idle(2);

    // Good A5 frame, even parity, strobe every 4 cycles
    clr_mon();
    if_a.out_ready = 1'b1;
    strobe_bits(1'b0, 32'(frame_a(8'hA5, 1'b0, 1'b1) >> 10), 1, 4);
    chk_eq("busy_after_start", busy_a, 1);
    strobe_bits(1'b0, 32'(frame_a(8'hA5, 1'b0, 1'b1)), 10, 4);
    idle(2);
    chk_eq("a5_count", got_a.size(), 1);
    if (got_a.size() > 0) chk_eq("a5_data", got_a[0], 8'hA5);
    chk_eq("a5_valid_cycles", nv_a, 1);
    chk_eq("a5_errs", np_a + nf_a + no_a, 0);
    chk_eq("a5_busy_end", busy_a, 0);

    // Bad parity then good 3C
    clr_mon();
    strobe_bits(1'b0, 32'(frame_a(8'hA5, 1'b1, 1'b1)), 11, 4);
    idle(2);
    chk_eq("perr_pulses", np_a, 1);
    chk_eq("perr_valid_cycles", nv_a, 0);
    strobe_bits(1'b0, 32'(frame_a(8'h3C, 1'b0, 1'b1)), 11, 4);
    idle(2);
    chk_eq("3c_count", got_a.size(), 1);
    if (got_a.size() > 0) chk_eq("3c_data", got_a[0], 8'h3C);
    chk_eq("3c_perr", np_a, 1);

    // Stop bit 0
    clr_mon();
    strobe_bits(1'b0, 32'(frame_a(8'h5A, 1'b0, 1'b0)), 11, 4);
    idle(2);
    chk_eq("ferr_pulses", nf_a, 1);
    chk_eq("ferr_count", got_a.size(), 0);
    chk_eq("ferr_perr", np_a, 0);
    chk_eq("ferr_busy", busy_a, 0);

    // Overrun: consumer stalled across two frames
    clr_mon();
    if_a.out_ready = 1'b0;
    strobe_bits(1'b0, 32'(frame_a(8'h11, 1'b0, 1'b1)), 11, 4);
    strobe_bits(1'b0, 32'(frame_a(8'h22, 1'b0, 1'b1)), 11, 4);
    idle(2);
    chk_eq("ovr_pulses", no_a, 1);
    chk_eq("ovr_valid", if_a.out_valid, 1);
    chk_eq("ovr_data", if_a.out_data, 8'h11);
    chk_eq("ovr_count", got_a.size(), 0);
    if_a.out_ready = 1'b1;
    idle(1);
    if_a.out_ready = 1'b0;
    idle(1);
    chk_eq("drain_count", got_a.size(), 1);
    chk_eq("drain_valid", if_a.out_valid, 0);

    // Ready rises on the second stop strobe: swap without overrun
    clr_mon();
    strobe_bits(1'b0, 32'(frame_a(8'h11, 1'b0, 1'b1)), 11, 4);
    strobe_bits(1'b0, 32'(frame_a(8'h22, 1'b0, 1'b1) >> 1), 10, 4);
    if_a.out_ready = 1'b1;
    strobe_bits(1'b0, 32'h1, 1, 4);
    idle(2);
    chk_eq("swap_ovr", no_a, 0);
    chk_eq("swap_count", got_a.size(), 2);
    if (got_a.size() > 1) begin
      chk_eq("swap_first", got_a[0], 8'h11);
      chk_eq("swap_second", got_a[1], 8'h22);
    end

    // Reset mid-frame, after 4 data bits
    clr_mon();
    if_a.out_ready = 1'b0;
    strobe_bits(1'b0, 32'(frame_a(8'hA5, 1'b0, 1'b1) >> 6), 5, 4);
    chk_eq("mid_busy", busy_a, 1);
    reset = 1'b1;
    #1;
    chk_eq("mid_rst_busy", busy_a, 0);
    chk_eq("mid_rst_valid", if_a.out_valid, 0);
    chk_eq("mid_rst_data", if_a.out_data, 32'h00);
    chk_eq("mid_rst_errs", {perr_a, ferr_a, ovr_a}, 0);
    idle(2);
    reset = 1'b0;
    idle(1);
    if_a.out_ready = 1'b1;
    strobe_bits(1'b0, 32'(frame_a(8'hFF, 1'b0, 1'b1)), 11, 4);
    idle(2);
    chk_eq("ff_count", got_a.size(), 1);
    if (got_a.size() > 0) chk_eq("ff_data", got_a[0], 8'hFF);
    chk_eq("ff_errs", np_a + nf_a + no_a, 0);

    // No parity, back-to-back frames with a strobe every cycle
    clr_mon();
    if_b.out_ready = 1'b1;
    strobe_bits(1'b1, {2'b11, frame_b(8'h00), frame_b(8'h80), frame_b(8'h01)}, 30, 1);
    idle(3);
    chk_eq("b2b_count", got_b.size(), 3);
    if (got_b.size() > 2) begin
      chk_eq("b2b_0", got_b[0], 8'h00);
      chk_eq("b2b_1", got_b[1], 8'h80);
      chk_eq("b2b_2", got_b[2], 8'h01);
    end
    chk_eq("b2b_errs", np_b + nf_b + no_b, 0);
    chk_eq("b2b_busy", busy_b, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
